// File: rtl/branch_resolve_if.sv
// Bundle between the pipeline (IF/EX) and the EX-stage branch resolver.
// Stat counters exist only when BR_RESOLVE_STATS_EN is defined.
interface branch_resolve_if;
  logic        stall;
  logic        if_br_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        q_full;
  logic        q_err;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output stall, if_br_valid, if_pc, if_pred_taken, if_pred_target,
    output ex_br_valid, ex_pc, ex_taken, ex_target,
    input  flush, redirect_pc, upd_valid, upd_taken, upd_mispredict,
    input  q_full, q_err, stat_branches, stat_mispredicts
  );
  modport slave (
    input  stall, if_br_valid, if_pc, if_pred_taken, if_pred_target,
    input  ex_br_valid, ex_pc, ex_taken, ex_target,
    output flush, redirect_pc, upd_valid, upd_taken, upd_mispredict,
    output q_full, q_err, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output stall, if_br_valid, if_pc, if_pred_taken, if_pred_target,
    output ex_br_valid, ex_pc, ex_taken, ex_target,
    input  flush, redirect_pc, upd_valid, upd_taken, upd_mispredict,
    input  q_full, q_err
  );
  modport slave (
    input  stall, if_br_valid, if_pc, if_pred_taken, if_pred_target,
    input  ex_br_valid, ex_pc, ex_taken, ex_target,
    output flush, redirect_pc, upd_valid, upd_taken, upd_mispredict,
    output q_full, q_err
  );
`endif
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: in-order prediction queue, mispredict flush.
// Optional stat counters: define BR_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic              clk,
  input logic              rst,
  branch_resolve_if.slave  bus
);
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} st_e;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  st_e st_q, st_d;
  logic run, flush_w;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0] pc_mem [DEPTH];
  logic        pt_mem [DEPTH];
  logic [31:0] tg_mem [DEPTH];

  logic empty, full, push, pop, bypass, wr_en, drop;
  logic [31:0] h_pc, h_tg, nxt_pc;
  logic        h_pt, mis, pc_bad;

  logic        uv_q, ut_q, um_q, err_q;
  logic [31:0] redir_q;

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push   = run & ~bus.stall & bus.if_br_valid;
  assign pop    = run & ~bus.stall & bus.ex_br_valid;
  assign bypass = push & pop & empty;
  assign wr_en  = push & ~bypass & (~full | pop);
  assign drop   = push & full & ~pop;
  assign nxt_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd8;

  // Head of queue, or the incoming IF entry when bypassing an empty queue
  always_comb begin
    h_pc = bus.ex_pc;
    h_pt = 1'b0;
    h_tg = '0;
    if (!empty) begin
      h_pc = pc_mem[rd_q[AW-1:0]];
      h_pt = pt_mem[rd_q[AW-1:0]];
      h_tg = tg_mem[rd_q[AW-1:0]];
    end else if (push) begin
      h_pc = bus.if_pc;
      h_pt = bus.if_pred_taken;
      h_tg = bus.if_pred_target;
    end
  end

  assign pc_bad = (h_pc != bus.ex_pc);
  assign mis = (bus.ex_taken != h_pt) |
               (bus.ex_taken & (bus.ex_target != h_tg)) |
               pc_bad;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= RUN;
    else      st_q <= st_d;
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:     if (pop & mis) st_d = FLUSH;
      FLUSH:   st_d = RUN;
      default: st_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run     = 1'b0;
    flush_w = 1'b0;
    case (st_q)
      RUN:     run = 1'b1;
      FLUSH:   flush_w = 1'b1;
      default: run = 1'b1;
    endcase
  end

  // Pointer next state; FLUSH empties the queue
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_w) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en)         wr_d = wr_q + ONE;
      if (pop && !empty) rd_d = rd_q + ONE;
    end
  end

  // Queue pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Queue storage (no reset needed; pointers qualify contents)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_q[AW-1:0]] <= bus.if_pc;
      pt_mem[wr_q[AW-1:0]] <= bus.if_pred_taken;
      tg_mem[wr_q[AW-1:0]] <= bus.if_pred_target;
    end
  end

  // Registered update strobe, redirect and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uv_q    <= 1'b0;
      ut_q    <= 1'b0;
      um_q    <= 1'b0;
      err_q   <= 1'b0;
      redir_q <= '0;
    end else begin
      uv_q  <= pop;
      ut_q  <= pop & bus.ex_taken;
      um_q  <= pop & mis;
      err_q <= err_q | drop |
               (pop & empty & ~push) | (pop & pc_bad);
      if (pop & mis) redir_q <= nxt_pc;
    end
  end

  assign bus.flush          = flush_w;
  assign bus.redirect_pc    = redir_q;
  assign bus.upd_valid      = uv_q;
  assign bus.upd_taken      = ut_q;
  assign bus.upd_mispredict = um_q;
  assign bus.q_full         = full;
  assign bus.q_err          = err_q;

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] sb_q, sm_q;

  // Saturating resolve / mispredict counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
      sm_q <= '0;
    end else begin
      if (pop && sb_q != 32'hFFFF_FFFF)
        sb_q <= sb_q + 32'd1;
      if (pop && mis && sm_q != 32'hFFFF_FFFF)
        sm_q <= sm_q + 32'd1;
    end
  end

  assign bus.stat_branches    = sb_q;
  assign bus.stat_mispredicts = sm_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve.
// Reference model: queue of predictions, resolved in order.
module tb_branch_resolve;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if bus();

  branch_resolve #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } ent_t;

  ent_t        mq[$];
  bit          m_fl, m_err, e_uv, e_ut, e_um;
  logic [31:0] e_rd, m_sb, m_sm;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fl = 0; m_err = 0;
    e_uv = 0; e_ut = 0; e_um = 0;
    e_rd = '0; m_sb = '0; m_sm = '0;
  endtask

  task automatic zero_in();
    bus.stall = 0;
    bus.if_br_valid = 0; bus.if_pc = '0;
    bus.if_pred_taken = 0; bus.if_pred_target = '0;
    bus.ex_br_valid = 0; bus.ex_pc = '0;
    bus.ex_taken = 0; bus.ex_target = '0;
  endtask

  task automatic model_step();
    ent_t h, inc;
    bit push, pop, mis;
    e_uv = 0;
    if (m_fl) begin
      mq.delete();
      m_fl = 0;
      return;
    end
    push = !bus.stall && bus.if_br_valid;
    pop  = !bus.stall && bus.ex_br_valid;
    inc = '{bus.if_pc, bus.if_pred_taken, bus.if_pred_target};
    if (pop) begin
      if (mq.size() > 0) h = mq.pop_front();
      else if (push) begin h = inc; push = 0; end
      else begin h = '{bus.ex_pc, 1'b0, 32'h0}; m_err = 1; end
      if (h.pc != bus.ex_pc) m_err = 1;
      mis = (bus.ex_taken != h.pt) ||
            (bus.ex_taken && bus.ex_target != h.tg) ||
            (h.pc != bus.ex_pc);
      e_uv = 1; e_ut = bus.ex_taken; e_um = mis;
      if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
      if (mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
      if (mis) begin
        m_fl = 1;
        e_rd = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd8;
      end
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(inc);
      else m_err = 1;
    end
  endtask

  task automatic check_all();
    chk("flush", bus.flush, m_fl);
    chk("redirect_pc", bus.redirect_pc, e_rd);
    chk("upd_valid", bus.upd_valid, e_uv);
    if (e_uv) begin
      chk("upd_taken", bus.upd_taken, e_ut);
      chk("upd_mispredict", bus.upd_mispredict, e_um);
    end
    chk("q_full", bus.q_full, mq.size() == DEPTH);
    chk("q_err", bus.q_err, m_err);
`ifdef BR_RESOLVE_STATS_EN
    chk("stat_branches", bus.stat_branches, m_sb);
    chk("stat_mispredicts", bus.stat_mispredicts, m_sm);
`endif
  endtask

  task automatic cyc(input bit st, input bit iv,
                     input logic [31:0] ipc, input bit ipt,
                     input logic [31:0] itg, input bit ev,
                     input logic [31:0] epc, input bit et,
                     input logic [31:0] etg);
    @(negedge clk);
    bus.stall = st;
    bus.if_br_valid = iv; bus.if_pc = ipc;
    bus.if_pred_taken = ipt; bus.if_pred_target = itg;
    bus.ex_br_valid = ev; bus.ex_pc = epc;
    bus.ex_taken = et; bus.ex_target = etg;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push1(input logic [31:0] pc, input bit pt,
                       input logic [31:0] tg);
    cyc(0, 1, pc, pt, tg, 0, 0, 0, 0);
  endtask

  task automatic res1(input logic [31:0] pc, input bit t,
                      input logic [31:0] tg);
    cyc(0, 0, 0, 0, 0, 1, pc, t, tg);
  endtask

  initial begin
    zero_in();
    model_reset();
    #12;
    chk("rst_flush", bus.flush, 0);
    chk("rst_redir", bus.redirect_pc, 0);
    chk("rst_upd", bus.upd_valid, 0);
    chk("rst_full", bus.q_full, 0);
    chk("rst_err", bus.q_err, 0);
    @(negedge clk);
    rst = 1;

    // correct taken prediction
    push1(32'h0040_0010, 1, 32'h0040_0040);
    res1(32'h0040_0010, 1, 32'h0040_0040);
    chk("t1_upd", bus.upd_valid, 1);
    chk("t1_tk", bus.upd_taken, 1);
    chk("t1_mis", bus.upd_mispredict, 0);
    chk("t1_fl", bus.flush, 0);
    idle();
    chk("t1_fl2", bus.flush, 0);

    // predicted taken, actually not taken
    push1(32'h0040_0020, 1, 32'h0040_0060);
    res1(32'h0040_0020, 0, 32'h0040_0060);
    chk("t2_mis", bus.upd_mispredict, 1);
    chk("t2_fl", bus.flush, 1);
    chk("t2_rd", bus.redirect_pc, 32'h0040_0028);
    idle();
    chk("t2_fl2", bus.flush, 0);

    // predicted not taken, actually taken; FLUSH-cycle push ignored
    push1(32'h0040_0100, 0, 32'h0);
    res1(32'h0040_0100, 1, 32'h0040_0200);
    chk("t3_fl", bus.flush, 1);
    chk("t3_rd", bus.redirect_pc, 32'h0040_0200);
    push1(32'h0040_0300, 1, 32'h0040_0400);
    chk("t3_fl2", bus.flush, 0);

    // fill, overflow, push+pop while full
    for (int i = 0; i < DEPTH; i++) begin
      push1(32'h0040_0500 + 32'(i * 4), 0, 32'h0);
      chk("t4_full", bus.q_full, i == DEPTH - 1);
    end
    chk("t4_err0", bus.q_err, 0);
    push1(32'h0040_0600, 0, 32'h0);
    chk("t4_err1", bus.q_err, 1);
    chk("t4_full5", bus.q_full, 1);
    cyc(0, 1, 32'h0040_0700, 0, 32'h0, 1, 32'h0040_0500, 0, 32'h0);
    chk("t4_pp_full", bus.q_full, 1);
    chk("t4_pp_mis", bus.upd_mispredict, 0);
    for (int i = 1; i < DEPTH; i++)
      res1(32'h0040_0500 + 32'(i * 4), 0, 32'h0);
    res1(32'h0040_0700, 0, 32'h0);
    chk("t4_drained", bus.q_full, 0);

    // stalled resolve
    push1(32'h0040_0800, 1, 32'h0040_0900);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 1, 32'h0040_0800, 1, 32'h0040_0900);
      chk("t5_stall_upd", bus.upd_valid, 0);
    end
    res1(32'h0040_0800, 1, 32'h0040_0900);
    chk("t5_upd", bus.upd_valid, 1);
    chk("t5_mis", bus.upd_mispredict, 0);
    idle();
    chk("t5_upd_once", bus.upd_valid, 0);

    // stats run, then reset in the middle of FLUSH
    zero_in();
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    push1(32'h0000_1000, 1, 32'h0000_1100);
    res1(32'h0000_1000, 1, 32'h0000_1100);
    push1(32'h0000_1200, 0, 32'h0);
    res1(32'h0000_1200, 0, 32'h0000_5555);
    push1(32'h0000_1300, 0, 32'h0);
    res1(32'h0000_1300, 1, 32'h0000_1400);
    chk("t6_fl", bus.flush, 1);
`ifdef BR_RESOLVE_STATS_EN
    chk("t6_sb", bus.stat_branches, 3);
    chk("t6_sm", bus.stat_mispredicts, 1);
`endif
    #2;
    zero_in();
    rst = 0;
    model_reset();
    #1;
    chk("t6_rst_fl", bus.flush, 0);
    chk("t6_rst_upd", bus.upd_valid, 0);
    chk("t6_rst_err", bus.q_err, 0);
`ifdef BR_RESOLVE_STATS_EN
    chk("t6_rst_sb", bus.stat_branches, 0);
    chk("t6_rst_sm", bus.stat_mispredicts, 0);
`endif
    @(negedge clk);
    rst = 1;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit st, iv, ipt, ev, et;
      logic [31:0] ipc, itg, epc, etg;
      ent_t hc;
      st  = ($urandom % 8) == 0;
      iv  = ($urandom % 2) == 0;
      ipc = $urandom & 32'hFFFF_FFFC;
      ipt = $urandom % 2;
      itg = $urandom & 32'hFFFF_FFFC;
      ev  = ($urandom % 8) < 3;
      if (mq.size() > 0) hc = mq[0];
      else if (iv) hc = '{ipc, ipt, itg};
      else hc = '{$urandom, 1'b0, 32'h0};
      epc = (($urandom % 8) == 0) ? $urandom : hc.pc;
      et  = (($urandom % 4) == 0) ? ~hc.pt : hc.pt;
      etg = (($urandom % 4) == 0) ? $urandom : hc.tg;
      cyc(st, iv, ipc, ipt, itg, ev, epc, et, etg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
